// File: rtl/apb_regbank_slave.sv
// rtl/apb_regbank_slave.sv - APB register bank with byte strobes, RW/RO/W1C registers, wait states and SLVERR
// Optional: define APB_PROT_CHECK_EN to reject unprivileged (APB_PROT[0]=0) writes with SLVERR.
module apb_regbank_slave #(
    parameter int                             DATAWIDTH   = 32,
    parameter int                             REGSNUM     = 8,
    parameter logic [REGSNUM-1:0]             RO_MASK     = '0,
    parameter logic [REGSNUM-1:0]             W1C_MASK    = '0,
    parameter int                             WAIT_STATES = 0,
    parameter logic [DATAWIDTH*REGSNUM-1:0]   RESET_VALUE = '0,
    localparam int                            ADDR_LSB    = DATAWIDTH / 32 + 1,
    localparam int                            STRBW       = DATAWIDTH / 8,
    localparam int                            AW          = (REGSNUM > 1) ? $clog2(REGSNUM) : 1
) (
    input  logic                           APB_CLK,
    input  logic                           APB_RESETn,
    input  logic                           APB_SEL,
    input  logic                           APB_ENABLE,
    input  logic                           APB_WRITE,
    input  logic [DATAWIDTH-1:0]           APB_ADDR,
    input  logic [DATAWIDTH-1:0]           APB_WDATA,
    input  logic [STRBW-1:0]               APB_STRB,
    input  logic [2:0]                     APB_PROT,
    output logic [DATAWIDTH-1:0]           APB_RDATA,
    output logic                           APB_READY,
    output logic                           APB_SLVERR,
    output logic [DATAWIDTH*REGSNUM-1:0]   RegsDataOut,
    input  logic [DATAWIDTH*REGSNUM-1:0]   RegsDataIn,
    input  logic [DATAWIDTH*REGSNUM-1:0]   RegsSetIn,
    output logic                           beWrdOut,
    output logic                           beReadOut,
    output logic [AW-1:0]                  RegsAddrOut
);

    localparam int IW = DATAWIDTH - ADDR_LSB;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [AW-1:0]          lat_idx;
    logic                   lat_oor;
    logic                   lat_write;
    logic [DATAWIDTH-1:0]   lat_wdata;
    logic [STRBW-1:0]       lat_strb;
    logic [DATAWIDTH-1:0]   regs      [REGSNUM];
    logic [DATAWIDTH-1:0]   regs_next [REGSNUM];
    logic [DATAWIDTH-1:0]   wmask;
    logic [DATAWIDTH-1:0]   rd_val;
    logic                   ro_hit;
    logic                   prot_err;
    logic                   acc_err;
    logic                   wr_ok;
    logic                   unused_in;

`ifdef APB_PROT_CHECK_EN
    logic lat_priv;
    assign prot_err = lat_write && !lat_priv;
`else
    assign prot_err = 1'b0;
`endif

    assign unused_in = ^{APB_PROT, APB_ADDR[ADDR_LSB-1:0], RegsDataIn, RegsSetIn};

    assign acc_err = lat_oor || (lat_write && ro_hit) || prot_err;
    assign wr_ok   = (state == WAIT) && (cnt == 4'd0) && lat_write && !acc_err;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < STRBW; b++) begin
            wmask[b*8 +: 8] = {8{lat_strb[b]}};
        end
    end

    always_comb begin
        ro_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < REGSNUM; i++) begin
            if (lat_idx == AW'(i)) begin
                ro_hit = RO_MASK[i];
                rd_val = RO_MASK[i] ? RegsDataIn[i*DATAWIDTH +: DATAWIDTH] : regs[i];
            end
        end
    end

    // Core-side set pulses are ORed in after the bus clear so a coincident set survives.
    always_comb begin
        for (int i = 0; i < REGSNUM; i++) begin
            regs_next[i] = regs[i];
            if (wr_ok && lat_idx == AW'(i)) begin
                if (W1C_MASK[i]) begin
                    regs_next[i] = regs[i] & ~(lat_wdata & wmask);
                end else if (!RO_MASK[i]) begin
                    regs_next[i] = (regs[i] & ~wmask) | (lat_wdata & wmask);
                end
            end
            if (W1C_MASK[i]) begin
                regs_next[i] = regs_next[i] | RegsSetIn[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < REGSNUM; i++) begin
            RegsDataOut[i*DATAWIDTH +: DATAWIDTH] = RO_MASK[i] ? RegsDataIn[i*DATAWIDTH +: DATAWIDTH] : regs[i];
        end
    end

    always_ff @(posedge APB_CLK or negedge APB_RESETn) begin
        if (!APB_RESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_idx     <= '0;
            lat_oor     <= 1'b0;
            lat_write   <= 1'b0;
            lat_wdata   <= '0;
            lat_strb    <= '0;
`ifdef APB_PROT_CHECK_EN
            lat_priv    <= 1'b0;
`endif
            APB_RDATA   <= '0;
            APB_READY   <= 1'b0;
            APB_SLVERR  <= 1'b0;
            beWrdOut    <= 1'b0;
            beReadOut   <= 1'b0;
            RegsAddrOut <= '0;
            for (int i = 0; i < REGSNUM; i++) begin
                regs[i] <= RO_MASK[i] ? '0 : RESET_VALUE[i*DATAWIDTH +: DATAWIDTH];
            end
        end else begin
            for (int i = 0; i < REGSNUM; i++) begin
                regs[i] <= regs_next[i];
            end
            APB_READY  <= 1'b0;
            APB_SLVERR <= 1'b0;
            beWrdOut   <= 1'b0;
            beReadOut  <= 1'b0;
            case (state)
                IDLE: begin
                    if (APB_SEL && !APB_ENABLE) begin
                        lat_idx     <= APB_ADDR[AW+ADDR_LSB-1:ADDR_LSB];
                        lat_oor     <= (APB_ADDR[DATAWIDTH-1:ADDR_LSB] >= IW'(REGSNUM));
                        lat_write   <= APB_WRITE;
                        lat_wdata   <= APB_WDATA;
                        lat_strb    <= APB_STRB;
`ifdef APB_PROT_CHECK_EN
                        lat_priv    <= APB_PROT[0];
`endif
                        RegsAddrOut <= APB_ADDR[AW+ADDR_LSB-1:ADDR_LSB];
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (APB_ENABLE) begin
                        cnt   <= WAIT_STATES[3:0];
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        APB_READY  <= 1'b1;
                        APB_SLVERR <= acc_err;
                        beWrdOut   <= lat_write && !acc_err;
                        beReadOut  <= !lat_write && !acc_err;
                        APB_RDATA  <= (lat_write || acc_err) ? '0 : rd_val;
                        state      <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb/tb_apb_regbank_slave.sv - self-checking bench for apb_regbank_slave (RO reg0, W1C reg1, 3 wait states)
module tb_apb_regbank_slave;

    localparam logic [255:0] RV = {32'h0, 32'h0, 32'h0, 32'h0, 32'h1357_9BDF, 32'h0, 32'h0000_00F0, 32'h0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0, enable = 1'b0, write = 1'b0;
    logic [31:0]  addr = '0, wdata = '0;
    logic [3:0]   strb = '0;
    logic [2:0]   prot = 3'b001;
    logic [31:0]  rdata;
    logic         ready, slverr, wr_pulse, rd_pulse;
    logic [255:0] regs_out;
    logic [255:0] regs_in = '0;
    logic [255:0] set_in = '0;
    logic [2:0]   addr_out;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_regs [8];
    logic [31:0] r_rdata;
    logic        r_err, r_wp, r_rp, r_to, r_rdy_after;
    int          r_lat;

    apb_regbank_slave #(
        .DATAWIDTH(32), .REGSNUM(8), .RO_MASK(8'b0000_0001), .W1C_MASK(8'b0000_0010),
        .WAIT_STATES(3), .RESET_VALUE(RV)
    ) dut (
        .APB_CLK(clk), .APB_RESETn(rst_n), .APB_SEL(sel), .APB_ENABLE(enable), .APB_WRITE(write),
        .APB_ADDR(addr), .APB_WDATA(wdata), .APB_STRB(strb), .APB_PROT(prot),
        .APB_RDATA(rdata), .APB_READY(ready), .APB_SLVERR(slverr),
        .RegsDataOut(regs_out), .RegsDataIn(regs_in), .RegsSetIn(set_in),
        .beWrdOut(wr_pulse), .beReadOut(rd_pulse), .RegsAddrOut(addr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_regs[i] = RV[i*32 +: 32];
    endtask

    task automatic check_regs(input string tag);
        for (int i = 1; i < 8; i++) chk(tag, regs_out[i*32 +: 32], exp_regs[i]);
    endtask

    // Caller is positioned 1 time unit after a rising edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        sel = 1'b1; enable = 1'b0; write = w; addr = a; wdata = d; strb = s; prot = p;
        @(posedge clk); #1;
        enable = 1'b1;
        r_lat = 0; r_to = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                r_lat = n; r_to = 1'b0;
                break;
            end
        end
        r_rdata = rdata; r_err = slverr; r_wp = wr_pulse; r_rp = rd_pulse;
        @(posedge clk); #1;
        r_rdy_after = ready;
        sel = 1'b0; enable = 1'b0;
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p);
        logic [31:0] idx;
        logic        e_err;
        logic [31:0] e_rd;
        idx   = a >> 2;
        e_err = (idx >= 8) || (w && idx == 0);
`ifdef APB_PROT_CHECK_EN
        e_err = e_err || (w && !p[0]);
`endif
        e_rd = 32'h0;
        if (!w && !e_err) e_rd = (idx == 0) ? regs_in[31:0] : exp_regs[idx];
        xfer(w, a, d, s, p);
        if (w && !e_err) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    if (idx == 1) exp_regs[1][b*8 +: 8] = exp_regs[1][b*8 +: 8] & ~d[b*8 +: 8];
                    else          exp_regs[idx][b*8 +: 8] = d[b*8 +: 8];
                end
            end
        end
        exp_regs[1] = exp_regs[1] | set_in[63:32];
        chk("timeout", {31'b0, r_to}, 32'h0);
        chk("latency", r_lat, 5);
        chk("slverr", {31'b0, r_err}, {31'b0, e_err});
        chk("wr_pulse", {31'b0, r_wp}, {31'b0, w && !e_err});
        chk("rd_pulse", {31'b0, r_rp}, {31'b0, !w && !e_err});
        chk("ready_1cyc", {31'b0, r_rdy_after}, 32'h0);
        chk("addr_out", {29'b0, addr_out}, idx & 32'h7);
        if (!w) chk("rdata", r_rdata, e_rd);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_slverr", {31'b0, slverr}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_pulses", {30'b0, wr_pulse, rd_pulse}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_addr_out", {29'b0, addr_out}, 32'h0);
        check_regs("rst_reg");

        // RW reg 2 partial-lane write
        access(1'b1, 32'h8, 32'hA5A5_1234, 4'b0011, 3'b001);
        access(1'b0, 32'h8, 32'h0, 4'b0000, 3'b001);
        chk("rw_lane_read", r_rdata, 32'h0000_1234);

        // W1C reg 1: clear the reset image, set, clear-with-set, clear
        access(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 3'b001);
        access(1'b0, 32'h4, 32'h0, 4'h0, 3'b001);
        chk("w1c_cleared", r_rdata, 32'h0);
        set_in[32] = 1'b1;
        @(posedge clk); #1;
        set_in[32] = 1'b0;
        exp_regs[1] = exp_regs[1] | 32'h1;
        access(1'b0, 32'h4, 32'h0, 4'h0, 3'b001);
        chk("w1c_set", r_rdata, 32'h1);
        set_in[32] = 1'b1;
        access(1'b1, 32'h4, 32'h1, 4'hF, 3'b001);
        set_in[32] = 1'b0;
        access(1'b0, 32'h4, 32'h0, 4'h0, 3'b001);
        chk("w1c_set_wins", r_rdata, 32'h1);
        access(1'b1, 32'h4, 32'h1, 4'hF, 3'b001);
        access(1'b0, 32'h4, 32'h0, 4'h0, 3'b001);
        chk("w1c_clear", r_rdata, 32'h0);

        // RO reg 0
        regs_in[31:0] = 32'hDEAD_BEEF;
        access(1'b0, 32'h0, 32'h0, 4'h0, 3'b001);
        chk("ro_read", r_rdata, 32'hDEAD_BEEF);
        access(1'b1, 32'h0, 32'h1111_2222, 4'hF, 3'b001);
        chk("ro_write_err", {31'b0, r_err}, 32'h1);

        // Out-of-range index
        access(1'b0, 32'h20, 32'h0, 4'h0, 3'b001);
        chk("oor_err", {31'b0, r_err}, 32'h1);
        chk("oor_rdata", r_rdata, 32'h0);

`ifdef APB_PROT_CHECK_EN
        access(1'b1, 32'h10, 32'h0BAD_0BAD, 4'hF, 3'b000);
        chk("prot_denied", {31'b0, r_err}, 32'h1);
        access(1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
        chk("prot_unchanged", r_rdata, 32'h0);
        access(1'b1, 32'h10, 32'h600D_600D, 4'hF, 3'b001);
        access(1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
        chk("prot_allowed", r_rdata, 32'h600D_600D);
`endif

        // Randomised accesses with idle-time W1C set pulses
        for (int t = 0; t < 60; t++) begin
            logic [31:0] idx;
            if ($urandom_range(0, 3) == 0) begin
                set_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
                exp_regs[1] = exp_regs[1] | set_in[63:32];
                set_in = '0;
            end
            idx = $urandom_range(0, 10);
            if (idx == 10) idx = 32'h40 + $urandom_range(0, 7);
            regs_in[31:0] = $urandom;
            access(1'($urandom_range(0, 1)), (idx << 2) | 32'($urandom_range(0, 3)), $urandom,
                   4'($urandom), 3'($urandom));
        end
        check_regs("rand_reg");

        // Reset asserted while the access is waiting
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h8; wdata = 32'hFFFF_FFFF; strb = 4'hF; prot = 3'b001;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'h0);
        model_reset();
        sel = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst_no_ready", {31'b0, ready}, 32'h0);
        end
        chk("midrst_reg2", regs_out[95:64], 32'h0);
        check_regs("midrst_reg");
        access(1'b0, 32'h8, 32'h0, 4'h0, 3'b001);
        chk("midrst_read2", r_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
